// File: rtl/fir_acc_decimator_if.sv
// -----------------------------------------------------------------------------
// fir_acc_decimator_if
// Groups the sample stream, the averaged-word FIFO handshake and the overflow
// status of fir_acc_decimator into one bundle.
//   master : producer/consumer side (drives samples, ready, flush, clear_ovf)
//   slave  : decimator side (drives average word, FIFO level, overflow)
// Signals:
//   i_sample_valid, i_sample[11:0], i_flush   sample stream into the decimator
//   o_avg_valid, o_avg_data[11:0], i_avg_ready FIFO head and pop handshake
//   o_fifo_level[FIFO_AW:0]                    number of stored words
//   o_overflow, i_clear_ovf                    sticky drop flag and its clear
//   o_avg_min/o_avg_max[11:0]                  block peaks (FIR_DEC_PEAK_EN only)
// -----------------------------------------------------------------------------
interface fir_acc_decimator_if #(
    parameter int FIFO_AW = 2
);
    logic               i_sample_valid;
    logic [11:0]        i_sample;
    logic               i_flush;
    logic               o_avg_valid;
    logic [11:0]        o_avg_data;
    logic               i_avg_ready;
    logic [FIFO_AW:0]   o_fifo_level;
    logic               o_overflow;
    logic               i_clear_ovf;
`ifdef FIR_DEC_PEAK_EN
    logic [11:0]        o_avg_min;
    logic [11:0]        o_avg_max;
`endif

    modport master (
        output i_sample_valid, i_sample, i_flush, i_avg_ready, i_clear_ovf,
        input  o_avg_valid, o_avg_data, o_fifo_level, o_overflow
`ifdef FIR_DEC_PEAK_EN
        , input o_avg_min, o_avg_max
`endif
    );

    modport slave (
        input  i_sample_valid, i_sample, i_flush, i_avg_ready, i_clear_ovf,
        output o_avg_valid, o_avg_data, o_fifo_level, o_overflow
`ifdef FIR_DEC_PEAK_EN
        , output o_avg_min, o_avg_max
`endif
    );
endinterface

// File: rtl/fir_acc_decimator.sv
// -----------------------------------------------------------------------------
// fir_acc_decimator
// Averages blocks of 2^DEC_LOG2 unsigned 12-bit samples (round half up) and
// queues each average in a small output FIFO of 2^FIFO_AW words. A finished
// average that finds the FIFO full (and no pop on the same edge) is dropped
// and sets a sticky overflow flag.
// Ports:
//   clk  single rising-edge clock
//   rst  synchronous active-high reset
//   bus  fir_acc_decimator_if.slave (sample stream, FIFO head/pop, status)
// Optional feature: define FIR_DEC_PEAK_EN to also track the min/max raw
// sample of each block and deliver them with the average (36-bit FIFO word).
// -----------------------------------------------------------------------------
module fir_acc_decimator #(
    parameter int DEC_LOG2 = 4,
    parameter int FIFO_AW  = 2
) (
    input logic                 clk,
    input logic                 rst,
    fir_acc_decimator_if.slave  bus
);
    localparam int ACC_W = 12 + DEC_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int HALF  = 1 << (DEC_LOG2 - 1);
`ifdef FIR_DEC_PEAK_EN
    localparam int DW = 36;
`else
    localparam int DW = 12;
`endif

    // ---------------- accumulator / block counter ----------------
    logic [ACC_W-1:0]    acc;
    logic [DEC_LOG2-1:0] cnt;
    logic [ACC_W-1:0]    acc_sum;
    logic [ACC_W-1:0]    rounded;
    logic                take;
    logic                last;
    logic [DW-1:0]       result_word;

    logic                pend_valid;
    logic [DW-1:0]       pend_word;

`ifdef FIR_DEC_PEAK_EN
    logic [11:0] min_q, max_q, min_next, max_next;
`endif

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        take    = bus.i_sample_valid && !bus.i_flush;
        last    = take && (cnt == '1);
        acc_sum = acc + ACC_W'(bus.i_sample);
        rounded = acc_sum + ACC_W'(HALF);
`ifdef FIR_DEC_PEAK_EN
        min_next    = (bus.i_sample < min_q) ? bus.i_sample : min_q;
        max_next    = (bus.i_sample > max_q) ? bus.i_sample : max_q;
        result_word = {max_next, min_next, rounded[DEC_LOG2 +: 12]};
`else
        result_word = rounded[DEC_LOG2 +: 12];
`endif
    end

    // Fractional bits are rounded away; the top bit can never be set since
    // the rounded sum is below 4096 * 2^DEC_LOG2.
    logic unused_round;
    assign unused_round = ^{rounded[ACC_W-1], rounded[DEC_LOG2-1:0]};

    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            cnt        <= '0;
            pend_valid <= 1'b0;
`ifdef FIR_DEC_PEAK_EN
            min_q      <= 12'd4095;
            max_q      <= 12'd0;
`endif
        end else begin
            // A completed block is written into the FIFO on the following
            // edge; a flush on that following edge does not cancel it.
            pend_valid <= last;
            if (bus.i_flush || last) begin
                acc   <= '0;
                cnt   <= '0;
`ifdef FIR_DEC_PEAK_EN
                min_q <= 12'd4095;
                max_q <= 12'd0;
`endif
            end else if (take) begin
                acc   <= acc_sum;
                cnt   <= cnt + 1'b1;
`ifdef FIR_DEC_PEAK_EN
                min_q <= min_next;
                max_q <= max_next;
`endif
            end
        end
    end

    // ---------------- output FIFO ----------------
    logic [DW-1:0]    mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0] level;
    logic             full, pop, push, drop;
    logic             ovf;
    logic [DW-1:0]    head;

    always_comb begin
        level = wr_ptr - rd_ptr;
        full  = level[FIFO_AW];           // level tops out at exactly DEPTH
        pop   = (level != '0) && bus.i_avg_ready;
        push  = pend_valid && (!full || pop);
        drop  = pend_valid && full && !pop;
        head  = mem[rd_ptr[FIFO_AW-1:0]];
    end

    // NOTE: the storage array and the pending data word carry no reset; the
    // pointers and pend_valid decide what is valid, and outputs are gated.
    always_ff @(posedge clk) begin
        if (last)
            pend_word <= result_word;
        if (push)
            mem[wr_ptr[FIFO_AW-1:0]] <= pend_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            // A drop on the same edge as a clear keeps the flag set.
            if (drop)
                ovf <= 1'b1;
            else if (bus.i_clear_ovf)
                ovf <= 1'b0;
        end
    end

    assign bus.o_avg_valid  = (level != '0);
    assign bus.o_avg_data   = bus.o_avg_valid ? head[11:0] : 12'd0;
    assign bus.o_fifo_level = level;
    assign bus.o_overflow   = ovf;
`ifdef FIR_DEC_PEAK_EN
    assign bus.o_avg_min    = bus.o_avg_valid ? head[23:12] : 12'd4095;
    assign bus.o_avg_max    = bus.o_avg_valid ? head[35:24] : 12'd0;
`endif
endmodule
